// File: rtl/ps_inserter_pkg.sv
// Shared types for the PacketStream packet inserter.
package ps_inserter_pkg;

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        INSERT = 1'b1
    } state_t;

endpackage

// File: rtl/ps_inserter.sv
// PacketStream inserter: injects a locally generated packet between inbound packets.
// Define PS_INSERTER_INCR_EN for an incrementing fill pattern instead of a constant one.
module ps_inserter
    import ps_inserter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LWIDTH = 16
) (
    input  logic              reset,
    input  logic              clk,
    input  logic              insert,
    input  logic [LWIDTH-1:0] ins_len,
    input  logic [WIDTH-1:0]  ins_dat,
    output logic              busy,
    output logic              winserted,
    output logic              pinserted,
    input  logic [WIDTH-1:0]  i_dat,
    input  logic              i_val,
    input  logic              i_eop,
    output logic              i_rdy,
    output logic [WIDTH-1:0]  o_dat,
    output logic              o_val,
    output logic              o_eop,
    input  logic              o_rdy
);

    // Handshake: a word moves on a side when val & rdy are both high at the clock edge;
    // a word offered with val high holds dat/eop until it is taken.

    localparam logic [LWIDTH-1:0] L_ONE = LWIDTH'(1);

    state_t            state;
    logic              bnd;
    logic [LWIDTH-1:0] cnt;
    logic [LWIDTH-1:0] len_q;
    logic [WIDTH-1:0]  dat_q;
    logic [WIDTH-1:0]  fill;
    logic              last;
    logic              grant;

`ifdef PS_INSERTER_INCR_EN
    assign fill = dat_q + WIDTH'(cnt);
`else
    assign fill = dat_q;
`endif

    assign last = (cnt == len_q - L_ONE);

    always_comb begin
        busy  = (state == INSERT);
        grant = (state == PASS) && bnd && insert && (ins_len != '0);
        o_dat = i_dat;
        o_val = i_val;
        o_eop = i_eop;
        i_rdy = o_rdy;
        if (busy) begin
            o_dat = fill;
            o_val = 1'b1;
            o_eop = last;
            i_rdy = 1'b0;
        end else if (grant) begin
            // Grant cycle is idle on both sides; first fill word follows next cycle.
            o_val = 1'b0;
            i_rdy = 1'b0;
        end
        winserted = busy && o_rdy;
        pinserted = winserted && o_eop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PASS;
            bnd   <= 1'b1;
            cnt   <= '0;
            len_q <= '0;
            dat_q <= '0;
        end else begin
            if (i_val && i_rdy) begin
                bnd <= i_eop;
            end
            case (state)
                PASS: begin
                    if (grant) begin
                        state <= INSERT;
                        len_q <= ins_len;
                        dat_q <= ins_dat;
                        cnt   <= '0;
                    end
                end
                INSERT: begin
                    if (o_rdy) begin
                        cnt <= cnt + L_ONE;
                        if (last) begin
                            state <= PASS;
                        end
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_ps_inserter.sv
// Self-checking bench for ps_inserter: vector table, directed corner sequences, random jobs.
module tb_ps_inserter;

    localparam int WIDTH  = 8;
    localparam int LWIDTH = 16;
    localparam int EW     = WIDTH + 2;

    logic              reset;
    logic              clk;
    logic              insert;
    logic [LWIDTH-1:0] ins_len;
    logic [WIDTH-1:0]  ins_dat;
    logic              busy;
    logic              winserted;
    logic              pinserted;
    logic [WIDTH-1:0]  i_dat;
    logic              i_val;
    logic              i_eop;
    logic              i_rdy;
    logic [WIDTH-1:0]  o_dat;
    logic              o_val;
    logic              o_eop;
    logic              o_rdy;

    ps_inserter #(.WIDTH(WIDTH), .LWIDTH(LWIDTH)) dut (
        .reset(reset), .clk(clk), .insert(insert), .ins_len(ins_len), .ins_dat(ins_dat),
        .busy(busy), .winserted(winserted), .pinserted(pinserted),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];   // {is_inserted, eop, data}
    logic mon_en = 1'b0;
    logic in_acc;
    logic pins_seen;
    logic prev_stall = 1'b0;
    logic [WIDTH:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fill word k of an inserted packet, straight from the pattern definition.
    function automatic logic [WIDTH-1:0] fill_word(input logic [WIDTH-1:0] base, input int k);
`ifdef PS_INSERTER_INCR_EN
        return WIDTH'((int'(base) + k) % (1 << WIDTH));
`else
        return base;
`endif
    endfunction

    task automatic observe();
        logic [EW-1:0] e;
        in_acc    = i_val && i_rdy;
        pins_seen = pinserted;
        if (mon_en) begin
            if (o_val && o_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(o_dat), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_dat", 32'(o_dat), 32'(e[WIDTH-1:0]));
                    check("out_eop", 32'(o_eop), 32'(e[WIDTH]));
                    check("winserted", 32'(winserted), 32'(e[WIDTH+1]));
                    check("pinserted", 32'(pinserted), 32'(e[WIDTH+1] & e[WIDTH]));
                end
            end else begin
                check("status_idle", 32'({winserted, pinserted}), 32'd0);
            end
            if (prev_stall) check("stall_hold", 32'({o_val, o_eop, o_dat}), 32'({1'b1, prev_out}));
            if (!busy && !insert) check("pass_through", 32'({o_val, i_rdy}), 32'({i_val, o_rdy}));
        end
        prev_stall = o_val && !o_rdy;
        prev_out   = {o_eop, o_dat};
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        insert = 1'b0; ins_len = '0; ins_dat = '0;
        i_val = 1'b0; i_dat = '0; i_eop = 1'b0; o_rdy = 1'b1;
    endtask

    // ---------------- driver ----------------
    // One job: an inbound packet of nw words, then (if ilen > 0) an inserted packet whose
    // request is raised only after the first inbound word has gone, i.e. mid-packet.
    task automatic run_job(input int nw, input int ilen, input logic [WIDTH-1:0] idat,
                           input int rdy_pct);
        logic [WIDTH-1:0] words[$];
        int sent = 0;
        int budget = 0;
        int limit;
        bit ins_pend;
        limit = 20 * (nw + ilen) + 100;
        ins_pend = (ilen > 0);
        for (int k = 0; k < nw; k++) begin
            words.push_back(WIDTH'($urandom));
            exp_q.push_back({1'b0, (k == nw - 1), words[k]});
        end
        for (int k = 0; k < ilen; k++) exp_q.push_back({1'b1, (k == ilen - 1), fill_word(idat, k)});
        ins_len = LWIDTH'(ilen);
        ins_dat = idat;
        while ((sent < nw || ins_pend) && budget < limit) begin
            if (sent < nw) begin
                if (!i_val) begin
                    i_val = ($urandom_range(0, 3) != 0);
                    i_dat = words[sent];
                    i_eop = (sent == nw - 1);
                end
            end else begin
                i_val = 1'b0;
            end
            o_rdy = ($urandom_range(0, 99) < rdy_pct);
            if (ins_pend && (nw == 0 || sent > 0)) insert = 1'b1;
            tick();
            if (in_acc) begin
                sent++;
                i_val = 1'b0;
            end
            if (pins_seen) begin
                ins_pend = 1'b0;
                insert   = 1'b0;
            end
            budget++;
        end
        insert = 1'b0;
        i_val  = 1'b0;
        if (budget >= limit) check("job_timeout", 32'(budget), 32'(limit - 1));
        check("job_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              ins;
        logic [LWIDTH-1:0] len;
        logic [WIDTH-1:0]  dat;
        logic              val;
        logic              eop;
        logic              rdy;
        logic [WIDTH-1:0]  x_dat;
        logic              x_val;
        logic              x_eop;
        logic              x_irdy;
        logic              chk_dat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 16'd0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 16'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'd0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'd3, 8'h91, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'd0, 8'h12, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'd1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        set_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_oval", 32'(o_val), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Combinational response at a boundary in PASS; inputs return to idle before the edge.
        foreach (vecs[i]) begin
            insert = vecs[i].ins; ins_len = vecs[i].len; ins_dat = 8'h5D;
            i_dat = vecs[i].dat; i_val = vecs[i].val; i_eop = vecs[i].eop; o_rdy = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_oval", i), 32'(o_val), 32'(vecs[i].x_val));
            check($sformatf("vec%0d_irdy", i), 32'(i_rdy), 32'(vecs[i].x_irdy));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            if (vecs[i].chk_dat) check($sformatf("vec%0d_out", i), 32'({o_eop, o_dat}),
                                       32'({vecs[i].x_eop, vecs[i].x_dat}));
            set_idle();
            @(posedge clk); #1;
        end

        // Request at a boundary with inbound waiting: idle grant cycle, 3 words, then resume.
        insert = 1'b1; ins_len = 16'd3; ins_dat = 8'hA5;
        i_val = 1'b1; i_dat = 8'h11; i_eop = 1'b1; o_rdy = 1'b1;
        #1;
        check("bnd_grant_idle", 32'({o_val, i_rdy, busy}), 32'd0);
        @(posedge clk); #1;
        insert = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bnd_word", 32'({busy, o_val, o_eop, pinserted, i_rdy, o_dat}),
                  32'({1'b1, 1'b1, (k == 2), (k == 2), 1'b0, fill_word(8'hA5, k)}));
            @(posedge clk); #1;
        end
        check("bnd_resume", 32'({busy, o_val, i_rdy, o_dat}), 32'({1'b0, 1'b1, 1'b1, 8'h11}));
        @(posedge clk); #1;
        set_idle();

        // Backpressure: downstream stalls 4 cycles on the first inserted word.
        insert = 1'b1; ins_len = 16'd3; ins_dat = 8'h5A;
        @(posedge clk); #1;
        insert = 1'b0; o_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_hold", 32'({o_val, o_eop, winserted, o_dat}),
                  32'({1'b1, 1'b0, 1'b0, fill_word(8'h5A, 0)}));
            @(posedge clk); #1;
        end
        o_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_word", 32'({o_val, o_eop, winserted, o_dat}),
                  32'({1'b1, (k == 2), 1'b1, fill_word(8'h5A, k)}));
            @(posedge clk); #1;
        end
        check("bp_done", 32'(busy), 32'd0);

        // ins_len = 0 never inserts.
        insert = 1'b1; ins_len = 16'd0; ins_dat = 8'hEE;
        i_val = 1'b1; i_dat = 8'h42; i_eop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("len0_pass", 32'({busy, o_val, i_rdy, o_dat}), 32'({1'b0, 1'b1, 1'b1, 8'h42}));
            @(posedge clk); #1;
        end
        set_idle();

        // ins_len = 1: single word, both status pulses together.
        insert = 1'b1; ins_len = 16'd1; ins_dat = 8'h33;
        @(posedge clk); #1;
        insert = 1'b0;
        #1;
        check("len1_word", 32'({o_val, o_eop, winserted, pinserted, o_dat}),
              32'({4'b1111, fill_word(8'h33, 0)}));
        @(posedge clk); #1;
        check("len1_done", 32'(busy), 32'd0);

        // Reset during word 2 of a 5-word insertion.
        insert = 1'b1; ins_len = 16'd5; ins_dat = 8'hFE;
        @(posedge clk); #1;
        insert = 1'b0;
        check("rst_word0", 32'({busy, o_dat}), 32'({1'b1, fill_word(8'hFE, 0)}));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_async", 32'({busy, o_val, i_rdy}), 32'({1'b0, 1'b0, 1'b1}));
        @(posedge clk); #1;
        reset = 1'b1;
        i_val = 1'b1; i_dat = 8'h5C; i_eop = 1'b1;
        #1;
        check("rst_pass", 32'({busy, o_val, o_eop, o_dat}), 32'({3'b011, 8'h5C}));
        @(posedge clk); #1;
        set_idle();

        // Scoreboard-checked jobs.
        prev_stall = 1'b0;
        mon_en = 1'b1;
        run_job(1, 0, 8'h00, 60);
        run_job(3, 0, 8'h00, 60);
        run_job(5, 0, 8'h00, 60);
        run_job(4, 2, 8'h77, 100);
        run_job(0, 4, 8'hFE, 100);
        run_job(0, 3, 8'h10, 40);
        run_job(0, 2, 8'h20, 100);
        for (int j = 0; j < 40; j++) begin
            int nw;
            int il;
            nw = $urandom_range(0, 5);
            il = $urandom_range(0, 4);
            if (nw == 0 && il == 0) nw = 1;
            run_job(nw, il, WIDTH'($urandom), $urandom_range(30, 100));
        end
        // Longest packet the length bus can describe.
        run_job(0, (1 << LWIDTH) - 1, 8'h3C, 100);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
